// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard unit between decode and execute. Forwards operands for NUM_SRC
//   decode sources from EX, MEM, load return and WB. Tracks up to MAX_LD
//   outstanding multi-cycle loads in a per-register scoreboard. Raises the
//   stall that holds fetch/decode and injects a bubble into EX.
//
//   Optional feature: define STALL_WDOG_EN to add a consecutive-stall
//   watchdog. When the watchdog count reaches WDOG_LIM it sets err.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   id_valid            decode instruction valid
//   id_src_addr/used    source register numbers and their read enables
//   rf_data             register-file read data, one word per source
//   ex_*/mem_*/wb_*     writeback candidates from EX, MEM and WB
//   ld_issue/ld_addr    load leaves EX toward memory
//   ld_done/_addr/_data load data returns from memory
//   src_data            forwarded operand per source
//   stall               hold fetch/decode
//   pending             one bit per register: a load to it is in flight
//   stall_cnt           saturating count of stall cycles
//   err                 sticky protocol / watchdog error
module hazard_scoreboard_unit #(
  parameter int REG_AW   = 3,
  parameter int DATA_W   = 16,
  parameter int NUM_SRC  = 2,
  parameter int MAX_LD   = 2,
  parameter int WDOG_LIM = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [NUM_SRC*DATA_W-1:0]   rf_data,
  input  logic                        ex_wr,
  input  logic [REG_AW-1:0]           ex_addr,
  input  logic [DATA_W-1:0]           ex_data,
  input  logic                        mem_wr,
  input  logic [REG_AW-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_data,
  input  logic                        wb_wr,
  input  logic [REG_AW-1:0]           wb_addr,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        ld_issue,
  input  logic [REG_AW-1:0]           ld_addr,
  input  logic                        ld_done,
  input  logic [REG_AW-1:0]           ld_done_addr,
  input  logic [DATA_W-1:0]           ld_done_data,
  output logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        stall,
  output logic [(2**REG_AW)-1:0]      pending,
  output logic [15:0]                 stall_cnt,
  output logic                        err
);

  localparam int NREG  = 2**REG_AW;
  localparam int CNT_W = $clog2(MAX_LD+1);
  localparam logic [CNT_W-1:0] LD_MAX = CNT_W'(MAX_LD);

  typedef enum logic [1:0] {RUN, LDWAIT, FULL} state_t;

  state_t             state_q, state_d;
  logic [NREG-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic [15:0]        stall_cnt_q, stall_cnt_d;
  logic               err_q, err_d;
  logic               dep_stall, full_stall, proto_err, wdog_hit;

  // Forwarding: assignments run lowest priority first so the youngest
  // producer (EX) overrides everything older.
  always_comb begin
    src_data = rf_data;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wb_wr && wb_addr == id_src_addr[i*REG_AW +: REG_AW])
        src_data[i*DATA_W +: DATA_W] = wb_data;
      if (ld_done && ld_done_addr == id_src_addr[i*REG_AW +: REG_AW])
        src_data[i*DATA_W +: DATA_W] = ld_done_data;
      if (mem_wr && mem_addr == id_src_addr[i*REG_AW +: REG_AW])
        src_data[i*DATA_W +: DATA_W] = mem_data;
      if (ex_wr && ex_addr == id_src_addr[i*REG_AW +: REG_AW])
        src_data[i*DATA_W +: DATA_W] = ex_data;
    end
  end

  // Stall causes. A load returning this cycle resolves its own dependency
  // because its data is forwarded above.
  always_comb begin
    dep_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i]) begin
        if (pending_q[id_src_addr[i*REG_AW +: REG_AW]] &&
            !(ld_done && ld_done_addr == id_src_addr[i*REG_AW +: REG_AW]))
          dep_stall = 1'b1;
        if (ld_issue && ld_addr == id_src_addr[i*REG_AW +: REG_AW])
          dep_stall = 1'b1;
      end
    end
    full_stall = (ld_cnt_q == LD_MAX) && !ld_done;
    stall      = id_valid && (dep_stall || full_stall);
  end

  // Stall-reason FSM; the dependency cause takes precedence over the limit.
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN, LDWAIT, FULL: begin
        if (id_valid && dep_stall)       state_d = LDWAIT;
        else if (id_valid && full_stall) state_d = FULL;
        else                             state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Scoreboard update. Issue is applied after done so that an issue and a
  // done to the same register in one cycle leave the bit set.
  always_comb begin
    pending_d = pending_q;
    if (ld_done)  pending_d[ld_done_addr] = 1'b0;
    if (ld_issue) pending_d[ld_addr]      = 1'b1;

    ld_cnt_d = ld_cnt_q;
    if (ld_issue && !ld_done && ld_cnt_q != LD_MAX) ld_cnt_d = ld_cnt_q + CNT_W'(1);
    if (ld_done && !ld_issue && ld_cnt_q != '0)     ld_cnt_d = ld_cnt_q - CNT_W'(1);

    proto_err = (ld_issue && pending_q[ld_addr] &&
                 !(ld_done && ld_done_addr == ld_addr)) ||
                (ld_done && !pending_q[ld_done_addr]) ||
                (ld_issue && ld_cnt_q == LD_MAX && !ld_done);

    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;

    err_d = err_q || proto_err || wdog_hit;
  end

`ifdef STALL_WDOG_EN
  localparam int WDOG_W = ($clog2(WDOG_LIM+1) > 8) ? $clog2(WDOG_LIM+1) : 8;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Counts consecutive stall cycles; any non-stall cycle restarts it.
  always_comb begin
    wdog_d = '0;
    if (stall) wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + WDOG_W'(1);
    wdog_hit = (wdog_d >= WDOG_W'(WDOG_LIM));
  end

  always_ff @(posedge clk) begin
    if (!rst) wdog_q <= '0;
    else      wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
  // The limit has no meaning without the watchdog; a zero limit is only
  // recognised here so the parameter keeps a defined role in this build.
  if (WDOG_LIM == 0) begin : g_wdog_lim_zero
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      pending_q   <= '0;
      ld_cnt_q    <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ld_cnt_q    <= ld_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pending   = pending_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
module tb_hazard_scoreboard_unit;

  localparam int REG_AW = 3, DATA_W = 16, NUM_SRC = 2, MAX_LD = 2;
  localparam int S_SRC0 = 0, S_SRC1 = 1, S_STALL = 2, S_PEND = 3, S_SCNT = 4, S_ERR = 5;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      id_valid;
  logic [NUM_SRC*REG_AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0]        id_src_used;
  logic [NUM_SRC*DATA_W-1:0] rf_data;
  logic                      ex_wr, mem_wr, wb_wr, ld_issue, ld_done;
  logic [REG_AW-1:0]         ex_addr, mem_addr, wb_addr, ld_addr, ld_done_addr;
  logic [DATA_W-1:0]         ex_data, mem_data, wb_data, ld_done_data;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      stall, err;
  logic [(2**REG_AW)-1:0]    pending;
  logic [15:0]               stall_cnt;

  hazard_scoreboard_unit #(.REG_AW(REG_AW), .DATA_W(DATA_W), .NUM_SRC(NUM_SRC),
                           .MAX_LD(MAX_LD), .WDOG_LIM(64)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .rf_data(rf_data),
    .ex_wr(ex_wr), .ex_addr(ex_addr), .ex_data(ex_data),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_issue(ld_issue), .ld_addr(ld_addr), .ld_done(ld_done),
    .ld_done_addr(ld_done_addr), .ld_done_data(ld_done_data),
    .src_data(src_data), .stall(stall), .pending(pending),
    .stall_cnt(stall_cnt), .err(err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t expq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] get_act(int s);
    case (s)
      S_SRC0:  return {16'h0, src_data[15:0]};
      S_SRC1:  return {16'h0, src_data[31:16]};
      S_STALL: return {31'h0, stall};
      S_PEND:  return {24'h0, pending};
      S_SCNT:  return {16'h0, stall_cnt};
      default: return {31'h0, err};
    endcase
  endfunction

  // Monitor: compares every expectation whose sample cycle has arrived.
  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] a;
      e = expq.pop_front();
      a = get_act(e.sig);
      n_cmp++;
      if (a !== e.val) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got %h, expected %h", e.name, cyc, a, e.val);
      end
    end
  end

  task automatic push(int at, int sig, logic [31:0] v, string n);
    exp_t e;
    e.cyc = at; e.sig = sig; e.val = v; e.name = n;
    expq.push_back(e);
  endtask

  task automatic chk(int sig, logic [31:0] v, string n);       push(cyc, sig, v, n);     endtask
  task automatic chk_next(int sig, logic [31:0] v, string n);  push(cyc + 1, sig, v, n); endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; id_src_addr = '0; id_src_used = '0; rf_data = '0;
    ex_wr = 0; ex_addr = '0; ex_data = '0;
    mem_wr = 0; mem_addr = '0; mem_data = '0;
    wb_wr = 0; wb_addr = '0; wb_data = '0;
    ld_issue = 0; ld_addr = '0; ld_done = 0; ld_done_addr = '0; ld_done_data = '0;
  endtask

  task automatic idsrc(logic [2:0] s0, logic [2:0] s1, logic [1:0] used);
    id_valid = 1; id_src_addr = {s1, s0}; id_src_used = used;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no summary, expected completion");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 0;
    step();
    chk(S_PEND, 32'h0, "reset_pending");
    chk(S_SCNT, 32'h0, "reset_stall_cnt");
    chk(S_ERR,  32'h0, "reset_err");
    chk(S_STALL, 32'h0, "reset_stall");
    step(); rst = 1;

    // Forwarding priority: EX over MEM, WB over register file.
    clr(); idsrc(3'd3, 3'd5, 2'b11); rf_data = {16'h5555, 16'h1111};
    ex_wr = 1; ex_addr = 3; ex_data = 16'h1234;
    mem_wr = 1; mem_addr = 3; mem_data = 16'hBEEF;
    wb_wr = 1; wb_addr = 5; wb_data = 16'hCAFE;
    chk(S_SRC0, 32'h1234, "fwd_ex_over_mem");
    chk(S_SRC1, 32'hCAFE, "fwd_wb");
    chk(S_STALL, 32'h0, "fwd_no_stall");
    step();
    clr(); idsrc(3'd3, 3'd5, 2'b11); rf_data = {16'h5555, 16'h1111};
    ex_wr = 1; ex_addr = 2; ex_data = 16'h1234;
    mem_wr = 1; mem_addr = 3; mem_data = 16'hBEEF;
    chk(S_SRC0, 32'hBEEF, "fwd_mem");
    chk(S_SRC1, 32'h5555, "fwd_rf");

    // Load r2, dependent decode stalls until the data returns.
    step(); clr(); ld_issue = 1; ld_addr = 2;
    chk(S_STALL, 32'h0, "ld_issue_no_id");
    chk_next(S_PEND, 32'h04, "pending_r2");
    step(); clr(); idsrc(3'd0, 3'd2, 2'b10);
    chk(S_STALL, 32'h1, "ld_use_stall");
    chk_next(S_SCNT, 32'd1, "stall_cnt_1");
    step(); clr(); idsrc(3'd0, 3'd2, 2'b10);
    ld_done = 1; ld_done_addr = 2; ld_done_data = 16'h00A5;
    wb_wr = 1; wb_addr = 2; wb_data = 16'h9999;
    chk(S_STALL, 32'h0, "ld_done_releases");
    chk(S_SRC1, 32'h00A5, "fwd_ld_done_over_wb");
    chk_next(S_PEND, 32'h00, "pending_clear_r2");
    chk_next(S_ERR, 32'h0, "no_err_after_r2");

    // Two loads outstanding: limit stall, released by a returning load.
    step(); clr(); ld_issue = 1; ld_addr = 1;
    step(); clr(); ld_issue = 1; ld_addr = 4;
    chk_next(S_PEND, 32'h12, "pending_r1_r4");
    step(); clr(); idsrc(3'd0, 3'd0, 2'b00);
    chk(S_STALL, 32'h1, "full_stall");
    chk_next(S_SCNT, 32'd2, "stall_cnt_2");
    step(); clr(); idsrc(3'd0, 3'd0, 2'b00); ld_done = 1; ld_done_addr = 1;
    chk(S_STALL, 32'h0, "full_released");
    chk_next(S_PEND, 32'h10, "pending_r4");
    step(); clr(); ld_done = 1; ld_done_addr = 4;
    chk_next(S_PEND, 32'h00, "pending_empty");

    // Load-use against the load issuing from EX this very cycle.
    step(); clr(); idsrc(3'd7, 3'd0, 2'b01); ld_issue = 1; ld_addr = 7;
    chk(S_STALL, 32'h1, "ex_load_use");
    chk_next(S_SCNT, 32'd3, "stall_cnt_3");
    chk_next(S_PEND, 32'h80, "pending_r7");
    step(); clr(); ld_done = 1; ld_done_addr = 7;

    // Same-cycle issue and done to the same pending register.
    step(); clr(); ld_issue = 1; ld_addr = 6;
    step(); clr(); ld_issue = 1; ld_addr = 6; ld_done = 1; ld_done_addr = 6;
    chk_next(S_PEND, 32'h40, "same_reg_stays_set");
    chk_next(S_ERR, 32'h0, "same_reg_no_err");
    step(); clr(); ld_issue = 1; ld_addr = 0;
    chk_next(S_PEND, 32'h41, "pending_r6_r0");
    step(); clr(); idsrc(3'd0, 3'd0, 2'b00);
    chk(S_STALL, 32'h1, "cnt_unchanged_full");
    step(); clr(); ld_done = 1; ld_done_addr = 6;
    step(); clr(); ld_done = 1; ld_done_addr = 0;
    chk_next(S_PEND, 32'h00, "pending_drained");
    chk_next(S_ERR, 32'h0, "drain_no_err");
    chk_next(S_SCNT, 32'd4, "stall_cnt_4");

    // Long dependent stall: 64 consecutive stall cycles.
    step(); clr(); ld_issue = 1; ld_addr = 3;
    for (int k = 1; k <= 64; k++) begin
      step(); clr(); idsrc(3'd3, 3'd0, 2'b01);
      if (k == 63) chk_next(S_ERR, 32'h0, "wdog_before_limit");
      if (k == 64) begin
`ifdef STALL_WDOG_EN
        chk_next(S_ERR, 32'h1, "wdog_err");
`else
        chk_next(S_ERR, 32'h0, "no_wdog_err");
`endif
        chk_next(S_SCNT, 32'd68, "stall_cnt_68");
      end
    end
    step(); clr(); ld_done = 1; ld_done_addr = 3;
    step(); clr(); rst = 0;
    step(); rst = 1;
    chk(S_ERR, 32'h0, "reset_clears_err");
    chk(S_SCNT, 32'h0, "reset_clears_scnt");

    // Done to a non-pending register: sticky error.
    step(); clr(); ld_done = 1; ld_done_addr = 5;
    chk_next(S_ERR, 32'h1, "err_done_not_pending");
    step(); clr();
    step(); clr(); ld_issue = 1; ld_addr = 1;
    chk(S_ERR, 32'h1, "err_sticky");
    chk_next(S_PEND, 32'h02, "pending_r1_before_reset");

    // Reset mid-operation discards the in-flight load.
    step(); clr(); rst = 0;
    step(); rst = 1;
    chk(S_ERR, 32'h0, "reset_clears_sticky_err");
    chk(S_PEND, 32'h00, "reset_discards_pending");
    idsrc(3'd1, 3'd0, 2'b01);
    chk(S_STALL, 32'h0, "no_stall_after_reset");

    repeat (3) step();
    clr();
    if (expq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d unchecked expectations, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
